acc_sat_n: RTL

- Parametrised signed two's-complement accumulator; successor to the team's fixed 8-bit overflow-detecting accumulator.
- Adds:
  - generic data width;
  - valid/ready input handshake;
  - selectable overflow policy: halt-and-hold or saturate-and-continue;
  - synchronous clear;
  - accepted-sample counter.
- Sits between a sample source and downstream logic that reads the running sum and status flags.

---
 rtl/acc_sat_n_if.sv | 45 ++++
 rtl/acc_sat_n.sv | 139 +++++++++++++
 2 files changed

// File: rtl/acc_sat_n_if.sv
// ---------------------------------------------------------------------------
// acc_sat_n_if
//   Bundles the sample handshake and result/status signals of acc_sat_n.
//
//   Signals:
//     clr        synchronous clear (source -> accumulator)
//     in_valid   in_data holds a sample (source -> accumulator)
//     in_data    signed sample, WIDTH bits (source -> accumulator)
//     in_ready   accumulator can take a sample (accumulator -> source)
//     acc        registered running sum, WIDTH bits
//     out_valid  one-cycle pulse, acc updated on the previous edge
//     carry      unsigned carry-out of the last accepted addition
//     overflow   sticky signed-overflow flag
//     sat_pulse  one-cycle pulse, last accepted addition was clamped
//     count      accepted-sample counter, CNT_W bits, holds at all-ones
//
//   Modports:
//     master  sample source / result consumer side
//     slave   accumulator side
// ---------------------------------------------------------------------------
interface acc_sat_n_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             clr;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] acc;
    logic             out_valid;
    logic             carry;
    logic             overflow;
    logic             sat_pulse;
    logic [CNT_W-1:0] count;

    modport master (
        output clr, in_valid, in_data,
        input  in_ready, acc, out_valid, carry, overflow, sat_pulse, count
    );

    modport slave (
        input  clr, in_valid, in_data,
        output in_ready, acc, out_valid, carry, overflow, sat_pulse, count
    );
endinterface

// File: rtl/acc_sat_n.sv
// ---------------------------------------------------------------------------
// acc_sat_n
//   Signed two's-complement accumulator with a valid/ready input, selectable
//   overflow policy (halt-and-hold or saturate-and-continue), synchronous
//   clear and a saturating accepted-sample counter.
//
//   Parameters:
//     WIDTH     data/accumulator width, signed, >= 2
//     SATURATE  0: halt and hold on overflow; 1: clamp and keep going
//     CNT_W     accepted-sample counter width
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   acc_sat_n_if.slave (clr, in_valid/in_data/in_ready,
//           acc, out_valid, carry, overflow, sat_pulse, count)
//
//   All outputs are registered except in_ready, decoded from the state.
// ---------------------------------------------------------------------------
module acc_sat_n #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    acc_sat_n_if.slave  bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc_q, acc_nx;
    logic [CNT_W-1:0] count_q, count_nx, count_inc;
    logic             carry_q, carry_nx;
    logic             overflow_q, overflow_nx;
    logic             out_valid_q, out_valid_nx;
    logic             sat_pulse_q, sat_pulse_nx;

    logic [WIDTH:0]   sum;
    logic             ovf;
    logic             accept;

    // Unsigned WIDTH+1-bit add: the top bit is the carry-out, the lower
    // WIDTH bits are the two's-complement result.
    assign sum = {1'b0, acc_q} + {1'b0, bus.in_data};

    // Signed overflow: operands share a sign and the result sign differs.
    assign ovf = (acc_q[WIDTH-1] == bus.in_data[WIDTH-1]) &&
                 (sum[WIDTH-1]   != acc_q[WIDTH-1]);

    // clr takes priority, so a sample presented with clr is never accepted.
    assign accept = (state == RUN) && bus.in_valid && !bus.clr;

    // Counter sticks at all-ones rather than wrapping.
    assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        state_nx     = state;
        acc_nx       = acc_q;
        count_nx     = count_q;
        carry_nx     = carry_q;
        overflow_nx  = overflow_q;
        out_valid_nx = 1'b0;
        sat_pulse_nx = 1'b0;

        if (bus.clr) begin
            state_nx    = RUN;
            acc_nx      = '0;
            count_nx    = '0;
            carry_nx    = 1'b0;
            overflow_nx = 1'b0;
        end else if (accept) begin
            carry_nx = sum[WIDTH];
            if (!ovf) begin
                acc_nx       = sum[WIDTH-1:0];
                out_valid_nx = 1'b1;
                count_nx     = count_inc;
            end else if (SATURATE) begin
                // Overflow only happens with equal operand signs, so the
                // accumulator sign tells which rail to clamp to.
                acc_nx       = acc_q[WIDTH-1] ? NEG_MIN : POS_MAX;
                overflow_nx  = 1'b1;
                sat_pulse_nx = 1'b1;
                out_valid_nx = 1'b1;
                count_nx     = count_inc;
            end else begin
                // Halt policy: keep the last good sum, flag it and stop.
                overflow_nx = 1'b1;
                state_nx    = HALT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sat_pulse_q <= 1'b0;
        end else begin
            acc_q       <= acc_nx;
            count_q     <= count_nx;
            carry_q     <= carry_nx;
            overflow_q  <= overflow_nx;
            out_valid_q <= out_valid_nx;
            sat_pulse_q <= sat_pulse_nx;
        end
    end

    assign bus.in_ready  = (state == RUN);
    assign bus.acc       = acc_q;
    assign bus.count     = count_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sat_pulse = sat_pulse_q;

endmodule
